// File: rtl/st_unit_pkg.sv
// -----------------------------------------------------------------------------
// st_unit_pkg
// Shared definitions for the store unit: store width codes (same encoding as
// the RV32 funct3 field for SB/SH/SW), the byte-strobe masks per width, the
// FSM state encoding, and small helpers used by the lane shifter.
// -----------------------------------------------------------------------------
package st_unit_pkg;

  // Store width codes.
  localparam logic [2:0] WIDTH_BYTE = 3'b000;
  localparam logic [2:0] WIDTH_HALF = 3'b001;
  localparam logic [2:0] WIDTH_WORD = 3'b010;

  // Byte-strobe mask of a right-justified store of each width.
  localparam logic [3:0] ST_MASK_BYTE = 4'b0001;
  localparam logic [3:0] ST_MASK_HALF = 4'b0011;
  localparam logic [3:0] ST_MASK_WORD = 4'b1111;
  localparam logic [3:0] ST_MASK_NONE = 4'b0000;

  // Store FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT1 = 3'd1,
    ST_BEAT2 = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } st_state_e;

  // Strobe mask for a width code; unsupported codes map to an empty mask.
  function automatic logic [3:0] width_mask(input logic [2:0] width);
    logic [3:0] mask;
    case (width)
      WIDTH_BYTE: mask = ST_MASK_BYTE;
      WIDTH_HALF: mask = ST_MASK_HALF;
      WIDTH_WORD: mask = ST_MASK_WORD;
      default:    mask = ST_MASK_NONE;
    endcase
    return mask;
  endfunction

  // True for the three supported width codes.
  function automatic logic width_supported(input logic [2:0] width);
    logic ok;
    case (width)
      WIDTH_BYTE: ok = 1'b1;
      WIDTH_HALF: ok = 1'b1;
      WIDTH_WORD: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_bits(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/st_lane_shift.sv
// -----------------------------------------------------------------------------
// st_lane_shift
// Purely combinational lane placement for a store. The right-justified store
// data is first trimmed to its width (so unused lanes carry zero), then shifted
// by the byte offset into a 64-bit image spanning two consecutive words. The
// strobe mask is shifted the same way into an 8-bit image.
//
// Ports:
//   width     in  3   store width code (Byte/Half/Word)
//   offset    in  2   byte offset inside the word (addr[1:0])
//   data      in  32  right-justified store data
//   data_img  out 64  lane-aligned data; [31:0] first word, [63:32] next word
//   strb_img  out 8   lane-aligned strobes; [3:0] first word, [7:4] next word
//   split     out 1   store touches the next word (strb_img[7:4] != 0)
//   bad_width out 1   width code is not Byte, Half or Word
// -----------------------------------------------------------------------------
module st_lane_shift
  import st_unit_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [63:0] data_img,
  output logic [7:0]  strb_img,
  output logic        split,
  output logic        bad_width
);

  logic [3:0]  mask_s;
  logic [31:0] lane_data_s;

  // Trim the data to its width, then place data and strobes by byte offset.
  always_comb begin
    mask_s      = width_mask(width);
    lane_data_s = data & strb_to_bits(mask_s);
    bad_width   = ~width_supported(width);
    case (offset)
      2'd0: begin
        data_img = {32'h0000_0000, lane_data_s};
        strb_img = {4'b0000, mask_s};
      end
      2'd1: begin
        data_img = {24'h00_0000, lane_data_s, 8'h00};
        strb_img = {3'b000, mask_s, 1'b0};
      end
      2'd2: begin
        data_img = {16'h0000, lane_data_s, 16'h0000};
        strb_img = {2'b00, mask_s, 2'b00};
      end
      2'd3: begin
        data_img = {8'h00, lane_data_s, 24'h00_0000};
        strb_img = {1'b0, mask_s, 3'b000};
      end
      default: begin
        data_img = 64'h0000_0000_0000_0000;
        strb_img = 8'h00;
      end
    endcase
    split = |strb_img[7:4];
  end

endmodule

// File: rtl/st_unit.sv
// -----------------------------------------------------------------------------
// st_unit
// Store path: accepts a store request (valid/ready), places byte/half/word data
// on the proper byte lanes of a 32-bit memory port with matching strobes, and
// issues one word-aligned bus beat (two when the store crosses a word boundary
// and splitting is enabled). All outputs are registered.
//
// Configuration macro: ST_MISALIGN_SPLIT_EN
//   defined     - word-crossing stores are issued as two beats (BEAT2 built)
//   not defined - word-crossing stores are rejected with an err pulse
//
// Ports:
//   clk        in  1   rising-edge clock
//   rst_n      in  1   asynchronous active-low reset
//   req_valid  in  1   store request valid
//   req_ready  out 1   unit idle and able to accept a request
//   req_width  in  3   store width code
//   req_addr   in  32  byte address
//   req_data   in  32  right-justified store data
//   mem_valid  out 1   bus beat valid
//   mem_ready  in  1   memory accepts the beat
//   mem_addr   out 32  word-aligned beat address
//   mem_wdata  out 32  lane-aligned write data
//   mem_wstrb  out 4   byte write enables
//   done       out 1   one-cycle pulse when a store completes
//   err        out 1   one-cycle pulse when a request is rejected
// -----------------------------------------------------------------------------
module st_unit
  import st_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        err
);

  st_state_e   state_r;
  st_state_e   state_nx_s;
  logic        accept_s;
  logic        beat_hs_s;
  logic [63:0] data_img_s;
  logic [7:0]  strb_img_s;
  logic        split_s;
  logic        bad_width_s;

`ifdef ST_MISALIGN_SPLIT_EN
  logic        pend_r;
  logic [31:0] hi_data_r;
  logic [3:0]  hi_strb_r;
`else
  // The upper image only feeds the second beat, which is not built here.
  logic        unused_hi_s;
  assign unused_hi_s = ^{data_img_s[63:32], strb_img_s[7:4]};
`endif

  st_lane_shift u_lane_shift (
    .width     (req_width),
    .offset    (req_addr[1:0]),
    .data      (req_data),
    .data_img  (data_img_s),
    .strb_img  (strb_img_s),
    .split     (split_s),
    .bad_width (bad_width_s)
  );

  // req_ready is a registered copy of "state is IDLE", so acceptance uses it.
  assign accept_s  = req_valid && req_ready;
  // mem_valid is high only in BEAT1/BEAT2, so mem_ready elsewhere is ignored.
  assign beat_hs_s = mem_valid && mem_ready;

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bad_width_s) begin
            state_nx_s = ST_ERR;
          end else if (split_s) begin
`ifdef ST_MISALIGN_SPLIT_EN
            state_nx_s = ST_BEAT1;
`else
            state_nx_s = ST_ERR;
`endif
          end else begin
            state_nx_s = ST_BEAT1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BEAT1: begin
        if (beat_hs_s) begin
`ifdef ST_MISALIGN_SPLIT_EN
          if (pend_r) begin
            state_nx_s = ST_BEAT2;
          end else begin
            state_nx_s = ST_DONE;
          end
`else
          state_nx_s = ST_DONE;
`endif
        end else begin
          state_nx_s = ST_BEAT1;
        end
      end
`ifdef ST_MISALIGN_SPLIT_EN
      ST_BEAT2: begin
        if (beat_hs_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_BEAT2;
        end
      end
`endif
      ST_DONE: state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register and control outputs, decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      req_ready <= 1'b0;
      mem_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      req_ready <= (state_nx_s == ST_IDLE);
      mem_valid <= (state_nx_s == ST_BEAT1) || (state_nx_s == ST_BEAT2);
      done      <= (state_nx_s == ST_DONE);
      err       <= (state_nx_s == ST_ERR);
    end
  end

  // Bus beat registers: load beat 1 at acceptance, beat 2 after the first
  // handshake, hold during stalls, and clear whenever no beat is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'b0000;
    end else if (accept_s && (state_nx_s == ST_BEAT1)) begin
      mem_addr  <= {req_addr[31:2], 2'b00};
      mem_wdata <= data_img_s[31:0];
      mem_wstrb <= strb_img_s[3:0];
`ifdef ST_MISALIGN_SPLIT_EN
    end else if ((state_r == ST_BEAT1) && (state_nx_s == ST_BEAT2)) begin
      // Next word; the add wraps modulo 2^32 at the top of the address space.
      mem_addr  <= mem_addr + 32'd4;
      mem_wdata <= hi_data_r;
      mem_wstrb <= hi_strb_r;
`endif
    end else if ((state_nx_s != ST_BEAT1) && (state_nx_s != ST_BEAT2)) begin
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'b0000;
    end else begin
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
      mem_wstrb <= mem_wstrb;
    end
  end

`ifdef ST_MISALIGN_SPLIT_EN
  // Second-beat image captured at acceptance; pending flag cleared on return
  // to IDLE so a stale split never leaks into the next store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r    <= 1'b0;
      hi_data_r <= 32'h0000_0000;
      hi_strb_r <= 4'b0000;
    end else if (accept_s) begin
      pend_r    <= split_s && !bad_width_s;
      hi_data_r <= data_img_s[63:32];
      hi_strb_r <= strb_img_s[7:4];
    end else if (state_nx_s == ST_IDLE) begin
      pend_r    <= 1'b0;
      hi_data_r <= 32'h0000_0000;
      hi_strb_r <= 4'b0000;
    end else begin
      pend_r    <= pend_r;
      hi_data_r <= hi_data_r;
      hi_strb_r <= hi_strb_r;
    end
  end
`endif

endmodule

// File: tb/tb_st_unit.sv
// -----------------------------------------------------------------------------
// tb_st_unit
// Self-checking bench for st_unit. A vector table drives stores; expected bus
// beats go into a queue and are popped by a monitor on each beat handshake.
// Hand-written sequences cover reset and a reset in the middle of a store.
// Follows ST_MISALIGN_SPLIT_EN so word-crossing vectors expect either two
// beats or a rejection.
// -----------------------------------------------------------------------------
module tb_st_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  typedef struct {
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    bit          exp_err;
    int          nbeats;
    beat_t       b1;
    beat_t       b2;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[10];

  st_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_width (req_width),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop expected beats on handshake, check stability across stalls.
  beat_t mon_e;
  beat_t prev_b;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_valid === 1'b1) begin
      if (prev_stall) begin
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== prev_b) begin
          failures++;
          $display("FAIL stall_hold got %h/%h/%b want %h/%h/%b", mem_addr, mem_wdata,
                   mem_wstrb, prev_b.addr, prev_b.wdata, prev_b.wstrb);
        end
      end
      if (mem_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got %h/%h/%b want no beat", mem_addr, mem_wdata, mem_wstrb);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.wdata || mem_wstrb !== mon_e.wstrb) begin
            failures++;
            $display("FAIL beat got %h/%h/%b want %h/%h/%b", mem_addr, mem_wdata, mem_wstrb,
                     mon_e.addr, mon_e.wdata, mon_e.wstrb);
          end
        end
      end
      prev_stall = (mem_ready !== 1'b1);
      prev_b     = {mem_addr, mem_wdata, mem_wstrb};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic vec_t mk(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d,
                              input int st, input int nb,
                              input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
                              input logic [31:0] a2, input logic [31:0] d2, input logic [3:0] s2);
    vec_t v;
    v.width   = w;
    v.addr    = a;
    v.data    = d;
    v.stall   = st;
    v.nbeats  = nb;
    v.exp_err = (nb == 0);
    v.b1      = {a1, d1, s1};
    v.b2      = {a2, d2, s2};
    return v;
  endfunction

  task automatic fail_line(input string name, input logic [31:0] got, input logic [31:0] want);
    failures++;
    $display("FAIL %s got %h want %h", name, got, want);
  endtask

  // Drive one store, then check completion timing, pulse kind and the return to idle.
  task automatic run_vec(input vec_t v, input int idx);
    int k;
    bit fin;
    int exp_k;
    logic exp_done;
    if (v.nbeats >= 1) exp_q.push_back(v.b1);
    if (v.nbeats == 2) exp_q.push_back(v.b2);
    exp_k    = v.exp_err ? 1 : (v.nbeats + v.stall + 1);
    exp_done = ~v.exp_err;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_width = v.width;
    req_addr  = v.addr;
    req_data  = v.data;
    mem_ready = (v.stall == 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) fail_line($sformatf("v%0d_ready_at_req", idx), {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_width = 3'($urandom);
    req_addr  = $urandom;
    req_data  = $urandom;
    fin = 1'b0;
    k   = 0;
    while (!fin && k < 30) begin
      k++;
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        fin = 1'b1;
        checks++;
        if (k != exp_k || err !== v.exp_err || done !== exp_done) begin
          failures++;
          $display("FAIL v%0d_end got cycle=%0d done=%b err=%b want cycle=%0d done=%b err=%b",
                   idx, k, done, err, exp_k, exp_done, v.exp_err);
        end
      end
      @(posedge clk); #1;
      mem_ready = ((k + 1) > v.stall);
    end
    if (!fin) begin
      checks++;
      fail_line($sformatf("v%0d_timeout", idx), k, exp_k);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL v%0d_after got done=%b err=%b ready=%b valid=%b want 0 0 1 0",
               idx, done, err, req_ready, mem_valid);
    end
    checks++;
    if (exp_q.size() != 0) fail_line($sformatf("v%0d_beats_left", idx), exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err} !== 72'd0) begin
      failures++;
      $display("FAIL %s got ready=%b valid=%b addr=%h wdata=%h wstrb=%b done=%b err=%b want all 0",
               name, req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err);
    end
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_width = 3'b000;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    mem_ready = 1'b0;

    //              width   addr          data          st nb  beat1                                 beat2
    vecs[0] = mk(3'b000, 32'h0000_1003, 32'hFFFF_FFA5, 0, 1, 32'h0000_1000, 32'hA500_0000, 4'b1000, 32'h0, 32'h0, 4'b0);
    vecs[1] = mk(3'b001, 32'h0000_2002, 32'h0000_BEEF, 3, 1, 32'h0000_2000, 32'hBEEF_0000, 4'b1100, 32'h0, 32'h0, 4'b0);
`ifdef ST_MISALIGN_SPLIT_EN
    vecs[2] = mk(3'b010, 32'h0000_3001, 32'h1122_3344, 0, 2, 32'h0000_3000, 32'h2233_4400, 4'b1110,
                 32'h0000_3004, 32'h0000_0011, 4'b0001);
    vecs[7] = mk(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 2, 32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000,
                 32'h0000_0000, 32'h0000_00BE, 4'b0001);
`else
    vecs[2] = mk(3'b010, 32'h0000_3001, 32'h1122_3344, 0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0);
    vecs[7] = mk(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0);
`endif
    vecs[3] = mk(3'b100, 32'h0000_4000, 32'h1234_5678, 0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0);
    vecs[4] = mk(3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 1, 1, 32'h0000_5000, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'b0);
    vecs[5] = mk(3'b000, 32'h0000_6000, 32'h1234_5678, 0, 1, 32'h0000_6000, 32'h0000_0078, 4'b0001, 32'h0, 32'h0, 4'b0);
    vecs[6] = mk(3'b001, 32'h0000_7001, 32'hCAFE_F00D, 0, 1, 32'h0000_7000, 32'h00F0_0D00, 4'b0110, 32'h0, 32'h0, 4'b0);
    vecs[8] = mk(3'b111, 32'h0000_9002, 32'h5555_AAAA, 0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0);
    vecs[9] = mk(3'b000, 32'h0000_8001, 32'hAABB_CCDD, 0, 1, 32'h0000_8000, 32'h0000_DD00, 4'b0010, 32'h0, 32'h0, 4'b0);

    // Reset state.
    #2;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n     = 1'b1;
    mem_ready = 1'b1;   // ignored while idle: the monitor flags any beat
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got ready=%b valid=%b want 1 0", req_ready, mem_valid);
    end

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of a store (second beat when splitting is built).
`ifdef ST_MISALIGN_SPLIT_EN
    exp_q.push_back({32'h0000_3000, 32'h2233_4400, 4'b1110});
    @(posedge clk); #1;
    req_valid = 1'b1; req_width = 3'b010; req_addr = 32'h0000_3001; req_data = 32'h1122_3344;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_3004) begin
      failures++;
      $display("FAIL midop_beat2 got valid=%b addr=%h want 1 00003004", mem_valid, mem_addr);
    end
`else
    @(posedge clk); #1;
    req_valid = 1'b1; req_width = 3'b001; req_addr = 32'h0000_2002; req_data = 32'h0000_BEEF;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_2000) begin
      failures++;
      $display("FAIL midop_beat1 got valid=%b addr=%h want 1 00002000", mem_valid, mem_addr);
    end
`endif
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_reset_immediate");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_all_zero("midop_reset_hold");
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_release got ready=%b done=%b err=%b valid=%b want 1 0 0 0",
               req_ready, done, err, mem_valid);
    end
    checks++;
    if (exp_q.size() != 0) fail_line("midop_beats_left", exp_q.size(), 32'd0);

    // A normal store still works after the mid-operation reset.
    run_vec(vecs[5], 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
